// File: rtl/fp32_pkg.sv
// Shared fp32 field layout, special encodings, FSM encoding and operand
// classification for the sequential floating-point arithmetic units.
package fp32_pkg;

    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int FP_W    = SIGN_W + EXP_W + MANT_W;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;
    localparam logic [FP_W-1:0] ZERO    = 32'h0000_0000;

    // FSM encoding kept as plain constants so older tools can share it.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_UNPACK = 3'd1;
    localparam state_t ST_DIVIDE = 3'd2;
    localparam state_t ST_NORM   = 3'd3;
    localparam state_t ST_ROUND  = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_NORM
    } fp_class_t;

    // Denormals classify as zero: the datapath flushes them.
    function automatic fp_class_t classify(input logic [EXP_W+MANT_W-1:0] x_mag);
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        e = x_mag[EXP_W+MANT_W-1:MANT_W];
        m = x_mag[MANT_W-1:0];
        if (e == '0)
            return CLS_ZERO;
        else if (e == '1)
            return (m == '0) ? CLS_INF : CLS_NAN;
        else
            return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_mant_div_iter.sv
// Restoring shift-subtract mantissa divider: one quotient bit per step.
// After QB steps from a load, q = floor(ma * 2^(QB-1) / mb).
module fp_mant_div_iter
    import fp32_pkg::*;
#(
    parameter int QB = 26
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [23:0]   ma,
    input  logic [23:0]   mb,
    output logic [QB-1:0] q,
    output logic [23:0]   rem,
    output logic          nonzero_rem
);

    // Partial remainder is kept pre-shifted; it always stays below 2*mb.
    logic [24:0]   r_rem;
    logic [23:0]   r_mb;
    logic [QB-1:0] r_q;
    logic [24:0]   w_sub;
    logic          w_ge;

    assign w_ge  = (r_rem >= {1'b0, r_mb});
    assign w_sub = r_rem - {1'b0, r_mb};

    // Load operands, then subtract-if-fits and shift once per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem <= '0;
            r_mb  <= '0;
            r_q   <= '0;
        end else if (load) begin
            r_rem <= {1'b0, ma};
            r_mb  <= mb;
            r_q   <= '0;
        end else if (step) begin
            r_rem <= w_ge ? (w_sub << 1) : (r_rem << 1);
            r_q   <= {r_q[QB-2:0], w_ge};
        end
    end

    assign q           = r_q;
    assign rem         = r_rem[24:1];
    assign nonzero_rem = |r_rem;

endmodule

// File: rtl/fp_divider_sequential.sv
// Iterative fp32 divider: start/done handshake, special-case decode,
// restoring mantissa division, normalization and round-to-nearest-even.
module fp_divider_sequential
    import fp32_pkg::*;
#(
    parameter logic [31:0] QNAN_VALUE = QNAN,
    parameter int          QUOT_BITS  = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);

    state_t              r_state;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic                r_sign;
    logic signed [9:0]   r_exp;
    logic [22:0]         r_frac;
    logic                r_guard;
    logic                r_sticky;
    logic [4:0]          r_cnt;
    logic [31:0]         r_result;
    logic                r_overflow;
    logic                r_underflow;
    logic                r_div_by_zero;
    logic                r_invalid;

    fp_class_t           w_cls_a;
    fp_class_t           w_cls_b;
    logic                w_sign;
    logic signed [9:0]   w_exp_unb;
    logic                w_special;
    logic [31:0]         w_spec_result;
    logic                w_spec_dbz;
    logic                w_spec_inv;
    logic                w_load;
    logic                w_step;
    logic [QUOT_BITS-1:0] w_q;
    logic [23:0]         w_rem;
    logic                w_nonzero_rem;
    logic                w_rem_any;
    logic                w_round_up;
    logic [23:0]         w_frac_inc;
    logic signed [9:0]   w_exp_rnd;
    logic                w_ovf;
    logic                w_unf;

    assign w_cls_a   = classify(r_a[30:0]);
    assign w_cls_b   = classify(r_b[30:0]);
    assign w_sign    = r_a[31] ^ r_b[31];
    assign w_exp_unb = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]})
                     + 10'(BIAS);

    // Resolve NaN/inf/zero operand combinations without running the divider.
    always_comb begin
        w_special     = 1'b0;
        w_spec_result = ZERO;
        w_spec_dbz    = 1'b0;
        w_spec_inv    = 1'b0;
        if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN ||
            (w_cls_a == CLS_ZERO && w_cls_b == CLS_ZERO) ||
            (w_cls_a == CLS_INF  && w_cls_b == CLS_INF)) begin
            w_special     = 1'b1;
            w_spec_result = QNAN_VALUE;
            w_spec_inv    = 1'b1;
        end else if (w_cls_b == CLS_ZERO) begin
            w_special     = 1'b1;
            w_spec_result = {w_sign, POS_INF[30:0]};
            w_spec_dbz    = 1'b1;
        end else if (w_cls_a == CLS_INF) begin
            w_special     = 1'b1;
            w_spec_result = {w_sign, POS_INF[30:0]};
        end else if (w_cls_a == CLS_ZERO || w_cls_b == CLS_INF) begin
            w_special     = 1'b1;
            w_spec_result = {w_sign, ZERO[30:0]};
        end
    end

    assign w_load = (r_state == ST_UNPACK) && !w_special;
    assign w_step = (r_state == ST_DIVIDE);

    fp_mant_div_iter #(.QB(QUOT_BITS)) u_mant_div (
        .clk         (clk),
        .rst         (rst),
        .load        (w_load),
        .step        (w_step),
        .ma          ({1'b1, r_a[22:0]}),
        .mb          ({1'b1, r_b[22:0]}),
        .q           (w_q),
        .rem         (w_rem),
        .nonzero_rem (w_nonzero_rem)
    );

    // Either remainder view flags inexactness; both are zero together.
    assign w_rem_any = w_nonzero_rem | (|w_rem);

    // Round on the fraction only: a carry out means 1.11..1 + ulp = 10.0,
    // whose fraction bits are already zero, so only the exponent moves.
    assign w_round_up = r_guard & (r_sticky | r_frac[0]);
    assign w_frac_inc = {1'b0, r_frac} + {23'd0, w_round_up};
    assign w_exp_rnd  = r_exp + $signed({9'd0, w_frac_inc[23]});
    assign w_ovf      = (w_exp_rnd >= 10'(EXP_MAX));
    assign w_unf      = (w_exp_rnd <= 10'sd0);

    // Main FSM: capture, decode, iterate, normalize, round, report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_sign        <= 1'b0;
            r_exp         <= '0;
            r_frac        <= '0;
            r_guard       <= 1'b0;
            r_sticky      <= 1'b0;
            r_cnt         <= '0;
            r_result      <= ZERO;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_invalid     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    if (w_special) begin
                        r_result      <= w_spec_result;
                        r_overflow    <= 1'b0;
                        r_underflow   <= 1'b0;
                        r_div_by_zero <= w_spec_dbz;
                        r_invalid     <= w_spec_inv;
                        r_state       <= ST_DONE;
                    end else begin
                        r_sign  <= w_sign;
                        r_exp   <= w_exp_unb;
                        r_cnt   <= '0;
                        r_state <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (r_cnt == 5'(QUOT_BITS - 1)) begin
                        r_state <= ST_NORM;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_NORM: begin
                    if (w_q[QUOT_BITS-1]) begin
                        r_frac   <= w_q[QUOT_BITS-2:2];
                        r_guard  <= w_q[1];
                        r_sticky <= w_q[0] | w_rem_any;
                    end else begin
                        r_frac   <= w_q[QUOT_BITS-3:1];
                        r_guard  <= w_q[0];
                        r_sticky <= w_rem_any;
                        r_exp    <= r_exp - 10'sd1;
                    end
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_div_by_zero <= 1'b0;
                    r_invalid     <= 1'b0;
                    r_overflow    <= w_ovf;
                    r_underflow   <= !w_ovf && w_unf;
                    if (w_ovf)
                        r_result <= {r_sign, POS_INF[30:0]};
                    else if (w_unf)
                        r_result <= {r_sign, ZERO[30:0]};
                    else
                        r_result <= {r_sign, w_exp_rnd[7:0], w_frac_inc[22:0]};
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign result      = r_result;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign div_by_zero = r_div_by_zero;
    assign invalid     = r_invalid;

endmodule

// File: tb/tb_fp_divider_sequential.sv
// Directed-vector bench for the sequential fp32 divider.
module tb_fp_divider_sequential;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        invalid;

    int n_checks;
    int n_fail;

    fp_divider_sequential dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {overflow, underflow, div_by_zero, invalid};
    endfunction

    // One divide: pulse start, find the done cycle (edges after acceptance),
    // check result/flags/latency, then check the unit returned to idle.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] er, input logic [3:0] ef, input int elat);
        int lat;
        lat = -1;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (done) lat = n;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_res"}, result, er);
        check({tag, "_flg"}, 32'(flags()), 32'(ef));
        $display("op %s a=%08h b=%08h result=%08h flags=%04b lat=%0d", tag, ta, tb_v, result, flags(), lat);
        @(posedge clk); #1;
        check({tag, "_idle"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        int first, second, busy_low, done_cnt;
        n_checks = 0;
        n_fail   = 0;
        start = 1'b0; a = '0; b = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res", result, 32'h0);
        check("rst_ctl", 32'({busy, done, flags()}), 32'd0);
        @(negedge clk); rst = 1'b1;

        // flags order: {overflow, underflow, div_by_zero, invalid}
        run_op("six_by_two",  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29);
        run_op("one_by_three",32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29);
        run_op("neg7p5_2p5",  32'hC0F00000, 32'h40200000, 32'hC0400000, 4'b0000, 29);
        run_op("div_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1);
        run_op("zero_zero",   32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1);
        run_op("inf_inf",     32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0001, 1);
        run_op("denorm",      32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1);
        run_op("nan_in",      32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4'b0001, 1);
        run_op("neg_inf_fin", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
        run_op("fin_by_inf",  32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 1);

        // Handshake: start held high, operands changed right after acceptance.
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        a = 32'h3F800000; b = 32'h40400000;
        first = -1; second = -1; busy_low = 0;
        for (int n = 1; n <= 70 && second < 0; n++) begin
            @(posedge clk); #1;
            if (n == 31) start = 1'b0;
            if (!busy) busy_low++;
            if (done) begin
                if (first < 0) begin
                    first = n;
                    check("hs_res1", result, 32'h40400000);
                end else begin
                    second = n;
                    check("hs_res2", result, 32'h3EAAAAAB);
                end
            end
        end
        check("hs_first", 32'(first), 32'd29);
        check("hs_gap", 32'(second - first), 32'd31);
        check("hs_idle_cycles", 32'(busy_low), 32'd1);
        $display("op handshake first=%0d second=%0d idle_cycles=%0d", first, second, busy_low);
        @(posedge clk); #1;
        check("hs_end", 32'({done, busy}), 32'd0);

        run_op("overflow",    32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b1000, 29);
        run_op("underflow",   32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 29);
        run_op("underflow_n", 32'h80800000, 32'h40000000, 32'h80000000, 4'b0100, 29);

        // Reset in the middle of DIVIDE aborts without a done pulse.
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_res", result, 32'h0);
        check("mid_rst_ctl", 32'({busy, done, flags()}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("mid_rst_nodone", 32'(done_cnt), 32'd0);
        $display("op mid_reset done_pulses=%0d", done_cnt);
        run_op("after_rst",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_divider_sequential.md
Name: fp_divider_sequential

Overview:
Iterative IEEE-754 single-precision divider. It is the inverse-operation companion to the team's sequential floating-point multiplier and shares its fp32 field conventions. Operands are captured on a start/done handshake. The mantissa quotient is produced one bit per clock by restoring shift-subtract, then normalized, rounded (nearest-even) and packed. It sits beside the multiplier in the arithmetic datapath and lets software-visible results be rescaled.

Parameters:
QNAN_VALUE, 32'h7FC0_0000, canonical quiet NaN returned for every NaN/invalid result
QUOT_BITS, 26, quotient bits computed per divide (24 mantissa + guard + one extra for normalization); fixed, not meant to be overridden

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request; accepted only in IDLE
a  input  32  dividend, fp32
b  input  32  divisor, fp32
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when result/flags are valid
result  output  32  quotient fp32, held until next done
overflow  output  1  result exponent overflowed to ±inf
underflow  output  1  nonzero exact result flushed to ±0
div_by_zero  output  1  finite nonzero / zero
invalid  output  1  0/0, inf/inf, or any NaN operand

Behaviour:
- Reset (rst=0, async): state=IDLE; result=0; all flags=0; done=0; busy=0. Reset mid-operation aborts without a done pulse.
- States: IDLE -> UNPACK -> DIVIDE -> NORM -> ROUND -> DONE -> IDLE.
- Let edge k be the edge where start=1 in IDLE. At edge k: a and b are latched, state->UNPACK. start is ignored in every other state, and the operand inputs are not re-sampled.
- UNPACK (edge k+1): decode fields. Denormal inputs are treated as ±0 (flush-to-zero). Special cases resolve here, write result/flags, and go straight to DONE:
  - NaN operand, 0/0, or inf/inf -> QNAN_VALUE, invalid=1.
  - finite nonzero/0 -> ±inf (7F800000 with sign), div_by_zero=1.
  - inf/finite -> ±inf, no flag.
  - 0/nonzero or finite/inf -> ±0, no flag.
  - The sign is always a[31]^b[31], except for NaN.
  - Otherwise: ma={1,a[22:0]}, mb={1,b[22:0]}, exp=ea-eb+127 (signed 10-bit), state->DIVIDE.
- DIVIDE: exactly QUOT_BITS cycles (edges k+2..k+27). Restoring division produces q=floor(ma*2^25/mb) plus a remainder rem. At edge k+27, state->NORM.
- NORM (edge k+28):
  - If q[25]=1: mant=q[25:2], guard=q[1], sticky=q[0]|(rem!=0).
  - Else: mant=q[24:1], guard=q[0], sticky=(rem!=0), and exp-=1.
- ROUND (edge k+29):
  - Round-to-nearest-even: increment when guard & (sticky | mant[0]). A carry out of mant sets mant=1.0 and exp+=1.
  - Then: exp>=255 -> ±inf, overflow=1. exp<=0 -> ±0, underflow=1. Otherwise pack {sign, exp[7:0], mant[22:0]}.
  - result and all flags are registered at this edge; state->DONE.
- DONE: done=1 for exactly one cycle, then IDLE. For the normal path, done is high in the cycle after edge k+29 (30-cycle latency). For the special path, done is high in the cycle after edge k+1.
- Flags update only together with result. The new op's values replace all four flags at once; there is no accumulation.
- start=1 in the same cycle as done is ignored. It is accepted on the next edge if still high in IDLE.

Decomposition:
- Shared package fp32_pkg holds:
  - field widths (SIGN/EXP/MANT), BIAS=127, EXP_MAX=255
  - QNAN, POS_INF and ZERO constants
  - the state enum
  - a classify function (zero/inf/nan/normal)
- One sub-module: fp_mant_div_iter, the restoring shift-subtract core.
  - Inputs: load, ma, mb.
  - Per cycle: step.
  - Outputs: q[25:0], rem, nonzero_rem.
- The top level owns the FSM, special-case decode, normalization and rounding.

Test Plan:
1. a=40C00000 (6.0), b=40000000 (2.0), start at edge k -> done in the cycle after k+29 only; result=40400000; all flags 0; busy high k+1..k+30.
2. a=3F800000 (1.0), b=40400000 (3.0) -> result=3EAAAAAB (round-up path). Then a=C0F00000 (-7.5), b=40200000 (2.5) -> C0400000.
3. Specials:
   - 3F800000/00000000 -> 7F800000, div_by_zero=1, done in the cycle after k+1.
   - 00000000/00000000 -> 7FC00000, invalid=1.
   - 7F800000/7F800000 -> 7FC00000, invalid=1.
   - 00400000 (denormal)/3F800000 -> 00000000, no flags.
4. Range:
   - 7F7FFFFF/3F000000 -> 7F800000, overflow=1.
   - 00800000/40000000 -> 00000000, underflow=1.
   - 80800000/40000000 -> 80000000, underflow=1.
5. Handshake: start held high with new operands throughout op 1 -> first result unaffected. A second done follows 31 cycles after the first with the new operands' quotient. busy never drops between the two ops except during the single IDLE cycle.
6. Reset: drive rst=0 during DIVIDE (edge k+10) -> result=0, flags=0, busy=0 immediately, no done pulse. After release, case 1 re-run gives 40400000 at the same latency.
